// File: rtl/smult_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// smult_pkg : widths and FSM encoding shared by the multiplier arbiter slice
// Rev 1.0
// ---------------------------------------------------------------------------
package smult_pkg;

   localparam int OP_W = 4;
   localparam int P_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/smult4bit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// smult4bit : combinational 4x4 signed multiplier, full 8-bit product
// Rev 1.0
// ---------------------------------------------------------------------------
module smult4bit
   import smult_pkg::*;
(
   input  logic signed [OP_W-1:0] a,
   input  logic signed [OP_W-1:0] b,
   output logic signed [P_W-1:0]  p
);

   logic signed [P_W-1:0] w_a_ext;

   assign w_a_ext = {{(P_W-OP_W){a[OP_W-1]}}, a};

   // The multiplier MSB carries weight -2^(OP_W-1), so its row is subtracted.
   always_comb begin
      p = '0;
      for (int i = 0; i < OP_W - 1; i++) begin
         if (b[i]) begin
            p = p + (w_a_ext <<< i);
         end
      end
      if (b[OP_W-1]) begin
         p = p - (w_a_ext <<< (OP_W - 1));
      end
   end

endmodule
`default_nettype wire

// File: rtl/smult4bit_arbiter_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick : round-robin priority selector, search starts at ptr
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic [NREQ-1:0] grant,
   output logic [ID_W-1:0] idx,
   output logic            found
);

   logic [ID_W-1:0] w_j;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      w_j   = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_j = ID_W'((int'(ptr) + k) % NREQ);
         if (!found && req[w_j]) begin
            found      = 1'b1;
            grant[w_j] = 1'b1;
            idx        = w_j;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/smult4bit_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// smult4bit_arbiter : round-robin sharing of one smult4bit among NREQ requesters
// Rev 1.0
// ---------------------------------------------------------------------------
module smult4bit_arbiter
   import smult_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*OP_W-1:0]   req_a,
   input  logic [NREQ*OP_W-1:0]   req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [P_W-1:0]         rsp_p,
   output logic [ID_W-1:0]        rsp_id
);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [ID_W-1:0]        r_rr_ptr;
   logic [ID_W-1:0]        r_cur_id;
   logic signed [OP_W-1:0] r_op_a;
   logic signed [OP_W-1:0] r_op_b;
   logic [NREQ-1:0]        w_grant;
   logic [ID_W-1:0]        w_idx;
   logic                   w_found;
   logic [OP_W-1:0]        w_sel_a;
   logic [OP_W-1:0]        w_sel_b;
   logic signed [P_W-1:0]  w_prod;
   logic [ID_W-1:0]        w_ptr_nxt;

   rr_pick #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_rr_pick (
      .req   (req_valid),
      .ptr   (r_rr_ptr),
      .grant (w_grant),
      .idx   (w_idx),
      .found (w_found)
   );

   smult4bit u_smult4bit (
      .a (r_op_a),
      .b (r_op_b),
      .p (w_prod)
   );

   // Operand lanes are OP_W=4 bits wide, so the lane base is idx*4.
   assign w_sel_a   = req_a[{w_idx, 2'b00} +: OP_W];
   assign w_sel_b   = req_b[{w_idx, 2'b00} +: OP_W];
   assign w_ptr_nxt = (r_cur_id == ID_W'(NREQ - 1)) ? '0 : r_cur_id + ID_W'(1);
   assign req_ready = (rst_n && (r_state == ST_IDLE)) ? w_grant : '0;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_found)   w_state_nxt = ST_MUL;
         ST_MUL:                 w_state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
         default:                w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_rr_ptr  <= '0;
         r_cur_id  <= '0;
         r_op_a    <= '0;
         r_op_b    <= '0;
         rsp_valid <= 1'b0;
         rsp_p     <= '0;
         rsp_id    <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_op_a   <= w_sel_a;
                  r_op_b   <= w_sel_b;
                  r_cur_id <= w_idx;
               end
            end
            ST_MUL: begin
               rsp_p     <= w_prod;
               rsp_id    <= r_cur_id;
               rsp_valid <= 1'b1;
            end
            ST_RESP: begin
               // Pointer moves only once the response is consumed.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_rr_ptr  <= w_ptr_nxt;
               end
            end
            default: rsp_valid <= 1'b0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_smult4bit_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_smult4bit_arbiter : directed bench with a transaction-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_smult4bit_arbiter;

   localparam int NREQ = 4;
   localparam int ID_W = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*4-1:0] req_a;
   logic [NREQ*4-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [7:0]        rsp_p;
   logic [ID_W-1:0]   rsp_id;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int qa [NREQ][$];
   int qb [NREQ][$];
   logic [NREQ-1:0] rdy_seen = '0;
   int acc_cyc [$];
   int log_id [$];
   int log_p [$];
   int rd = 0;

   // reference model state
   bit         m_busy   = 1'b0;
   int         m_stage  = 0;
   int         m_ptr    = 0;
   int         m_id     = 0;
   logic [7:0] m_prod   = '0;
   bit         m_out_v  = 1'b0;
   logic [7:0] m_out_p  = '0;
   int         m_out_id = 0;

   smult4bit_arbiter #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_p     (rsp_p),
      .rsp_id    (rsp_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int rr_first(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [7:0] mul8(input int g);
      logic signed [3:0] sa, sb;
      int p;
      sa = req_a[g*4 +: 4];
      sb = req_b[g*4 +: 4];
      p  = int'(sa) * int'(sb);
      return p[7:0];
   endfunction

   // Model: one transaction at a time, product shows one cycle after accept.
   always @(posedge clk) begin
      int g;
      cyc++;
      if (!rst_n) begin
         m_busy = 1'b0; m_stage = 0; m_ptr = 0;
         m_out_v = 1'b0; m_out_p = '0; m_out_id = 0;
      end else if (!m_busy) begin
         g = rr_first(req_valid, m_ptr);
         if (g >= 0) begin
            m_busy = 1'b1; m_stage = 0; m_id = g; m_prod = mul8(g);
         end
      end else if (m_stage == 0) begin
         m_stage = 1; m_out_v = 1'b1; m_out_p = m_prod; m_out_id = m_id;
      end else if (rsp_ready) begin
         m_out_v = 1'b0; m_busy = 1'b0; m_ptr = (m_id + 1) % NREQ;
      end
   end

   always @(negedge clk) begin
      logic [NREQ-1:0] exp_rdy;
      int g;
      exp_rdy = '0;
      if (rst_n && !m_busy) begin
         g = rr_first(req_valid, m_ptr);
         if (g >= 0) exp_rdy[g] = 1'b1;
      end
      check("req_ready", req_ready, exp_rdy);
      check("rsp_valid", rsp_valid, m_out_v);
      check("rsp_p", rsp_p, m_out_p);
      check("rsp_id", rsp_id, m_out_id);
      rdy_seen = req_ready;
      if (req_ready != '0) acc_cyc.push_back(cyc);
      if (rsp_valid && rsp_ready) begin
         log_id.push_back(int'(rsp_id));
         log_p.push_back(int'(rsp_p));
      end
   end

   // Requester drivers: hold each pair until it is accepted.
   always @(posedge clk) begin
      int t;
      #2;
      for (int i = 0; i < NREQ; i++) begin
         if (rdy_seen[i] && qa[i].size() > 0) begin
            void'(qa[i].pop_front());
            void'(qb[i].pop_front());
         end
         req_valid[i] = (qa[i].size() > 0);
         if (qa[i].size() > 0) begin
            t = qa[i][0]; req_a[i*4 +: 4] = t[3:0];
            t = qb[i][0]; req_b[i*4 +: 4] = t[3:0];
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int i, input int a, input int b);
      qa[i].push_back(a);
      qb[i].push_back(b);
   endtask

   task automatic wait_done(input string nm);
      int pend;
      pend = 1;
      for (int k = 0; k < 200 && pend != 0; k++) begin
         tick(1);
         pend = int'(m_busy);
         for (int i = 0; i < NREQ; i++) pend += qa[i].size();
      end
      check({nm, "_drain"}, pend, 0);
   endtask

   task automatic wait_rsp(input string nm);
      for (int k = 0; k < 50 && !rsp_valid; k++) tick(1);
      check({nm, "_rsp_seen"}, rsp_valid, 1'b1);
   endtask

   task automatic expect_resp(input string nm, input int id, input logic [7:0] p);
      if (rd < log_id.size()) begin
         check({nm, "_id"}, log_id[rd], id);
         check({nm, "_p"}, log_p[rd], p);
      end else begin
         check({nm, "_missing"}, log_id.size(), rd + 1);
      end
      rd++;
   endtask

   initial begin
      int a0;
      rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      tick(2);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_rsp_p", rsp_p, 8'h00);
      check("reset_rsp_id", rsp_id, 2'd0);
      check("reset_req_ready", req_ready, 4'b0000);
      rst_n = 1'b1;

      // single request
      push(0, -7, 1);
      wait_done("t1");
      expect_resp("t1", 0, 8'hF9);

      // all four valid from a fresh pointer
      rst_n = 1'b0; tick(1); rst_n = 1'b1;
      a0 = acc_cyc.size();
      push(0, 6, -1); push(1, 5, -8); push(2, -6, -7); push(3, -3, -1);
      wait_done("t2");
      expect_resp("t2_r0", 0, 8'hFA);
      expect_resp("t2_r1", 1, 8'hD8);
      expect_resp("t2_r2", 2, 8'h2A);
      expect_resp("t2_r3", 3, 8'h03);
      check("t2_accepts", acc_cyc.size() - a0, 4);
      if (acc_cyc.size() - a0 == 4) begin
         for (int k = 1; k < 4; k++) check("t2_spacing", acc_cyc[a0+k] - acc_cyc[a0+k-1], 3);
      end

      // boundary operands through requester 2
      push(2, -8, -8); push(2, -8, 7); push(2, 0, -5);
      wait_done("t3");
      expect_resp("t3_m8m8", 2, 8'h40);
      expect_resp("t3_m8p7", 2, 8'hC8);
      expect_resp("t3_zero", 2, 8'h00);

      // pointer at 3: r3 before r1, then wrap
      push(1, -1, -1); push(3, 7, 7);
      wait_done("t5");
      expect_resp("t5_first", 3, 8'h31);
      expect_resp("t5_second", 1, 8'h01);

      // consumer stall
      rsp_ready = 1'b0;
      push(0, -4, 5); push(1, 1, 1);
      wait_rsp("t4");
      tick(10);
      check("t4_hold_p", rsp_p, 8'hEC);
      check("t4_hold_v", rsp_valid, 1'b1);
      check("t4_no_ready", req_ready, 4'b0000);
      rsp_ready = 1'b1;
      wait_done("t4");
      expect_resp("t4_first", 0, 8'hEC);
      expect_resp("t4_second", 1, 8'h01);

      // reset while a response is held
      rsp_ready = 1'b0;
      push(1, 2, 3);
      wait_rsp("t6");
      push(0, 1, 2); push(2, 3, 1);
      tick(2);
      rst_n = 1'b0; tick(1); rst_n = 1'b1;
      check("t6_rsp_valid", rsp_valid, 1'b0);
      check("t6_rsp_p", rsp_p, 8'h00);
      rsp_ready = 1'b1;
      wait_done("t6");
      expect_resp("t6_first", 0, 8'h02);
      expect_resp("t6_second", 2, 8'h03);
      check("t6_no_extra", log_id.size(), rd);

      tick(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
`default_nettype wire
